addr_gen_bp_wr_dx: RTL

Write-side address generator for δx results in LSTM backpropagation (BP). It is the counterpart of the BP δgates/W-U read address generator. The downstream dot-product unit emits one δx[t][j] result per completed NUM_CELL-length accumulation. This block captures each result and produces the RAM write address, data and write enable. Results arrive timestep-descending (t = TIMESTEP-1 down to 0), with input index j ascending 0..NUM_INPUT-1 within each timestep.

---
 rtl/addr_gen_bp_wr_dx.sv | 96 +++++++++
 1 files changed

// File: rtl/addr_gen_bp_wr_dx.sv
// addr_gen_bp_wr_dx: captures BP dx results from the MAC and emits RAM write address/data/enable,
// walking timesteps descending and inputs ascending within each timestep.
module addr_gen_bp_wr_dx #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int TIMESTEP   = 7,
  parameter int NUM_INPUT  = 53,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [ADDR_WIDTH-1:0] T_LAST = ADDR_WIDTH'(TIMESTEP - 1);
  localparam logic [ADDR_WIDTH-1:0] J_LAST = ADDR_WIDTH'(NUM_INPUT - 1);
  localparam logic [ADDR_WIDTH-1:0] NI     = ADDR_WIDTH'(NUM_INPUT);
  localparam logic [ADDR_WIDTH-1:0] ROW0   = ADDR_WIDTH'(BASE_ADDR + NUM_INPUT * (TIMESTEP - 1));
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   t_q, t_d, j_q, j_d, row_q, row_d, addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    we_q, we_d, done_q, done_d, err_q, err_d;
  logic                    accept, last;
  assign accept = state_q == RUN && i_valid && !i_start;
  assign last   = t_q == '0 && j_q == J_LAST;
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    j_d     = j_q;
    row_d   = row_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    done_d  = done_q;
    err_d   = err_q;
    if (i_start) begin
      state_d = RUN;
      t_d     = T_LAST;
      j_d     = '0;
      row_d   = ROW0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else if (accept) begin
      we_d   = 1'b1;
      addr_d = row_q + j_q;
      data_d = i_data;
      if (last) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        j_d   = j_q == J_LAST ? '0 : j_q + 1'b1;
        t_d   = j_q == J_LAST ? t_q - 1'b1 : t_q;
        row_d = j_q == J_LAST ? row_q - NI : row_q;
      end
    end else if (i_valid) begin
      err_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= T_LAST;
      j_q     <= '0;
      row_q   <= ROW0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      j_q     <= j_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign o_we   = we_q;
  assign o_addr = addr_q;
  assign o_data = data_q;
  assign o_busy = state_q == RUN;
  assign o_done = done_q;
  assign o_err  = err_q;
endmodule
